// File: rtl/sync_fifo_16x2048_pkg.sv
// Shared constants for the 2048x16 single-clock video FIFO.
// Level and pointer widths carry one extra bit so a full FIFO (2048) is representable.
package sync_fifo_16x2048_pkg;

  localparam int DEPTH_WIDTH = 11;
  localparam int DATA_WIDTH  = 16;
  localparam int DEPTH       = 1 << DEPTH_WIDTH;
  localparam int PTR_WIDTH   = DEPTH_WIDTH + 1;

  localparam int ALMOST_FULL_DEFAULT  = 1020;
  localparam int ALMOST_EMPTY_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo_16x2048_if.sv
// Producer/consumer bundle for the video FIFO.
// The master side drives the write/read requests; the slave side is the FIFO itself.
interface sync_fifo_16x2048_if;
  import sync_fifo_16x2048_pkg::*;

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  wr_full;
  logic [PTR_WIDTH-1:0]  wr_water_level;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;
  logic                  rd_empty;
  logic [PTR_WIDTH-1:0]  rd_water_level;
  logic                  almost_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, wr_water_level, almost_full,
    input  rd_data, rd_empty, rd_water_level, almost_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, wr_water_level, almost_full,
    output rd_data, rd_empty, rd_water_level, almost_empty
  );

endinterface

// File: rtl/sync_fifo_16x2048_ram.sv
// 2048x16 simple dual-port RAM: one write port, one read port with a registered,
// read-enabled output that clears on reset (the array itself is never cleared).
module fifo_sdp_ram
  import sync_fifo_16x2048_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [DEPTH_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   re,
  input  logic [DEPTH_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_16x2048.sv
// Single-clock 2048x16 FIFO with registered full/empty, almost flags and fill levels.
// Pointers carry a wrap bit, so their difference is the word count directly.
module sync_fifo_16x2048
  import sync_fifo_16x2048_pkg::*;
#(
  parameter int ALMOST_FULL_NUM  = ALMOST_FULL_DEFAULT,
  parameter int ALMOST_EMPTY_NUM = ALMOST_EMPTY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_16x2048_if.slave bus
);

  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr_next, rd_ptr_next;
  logic [PTR_WIDTH-1:0] count_next;
  logic [PTR_WIDTH-1:0] level;
  logic                 full, empty, afull, aempty;
  logic                 wr_acc, rd_acc;

  // Acceptance uses the registered flags, so full+both favours the read and empty+both the write.
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (wr_acc) wr_ptr_next = wr_ptr + PTR_WIDTH'(1);
    if (rd_acc) rd_ptr_next = rd_ptr + PTR_WIDTH'(1);
    count_next = wr_ptr_next - rd_ptr_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      level  <= count_next;
      full   <= (count_next == PTR_WIDTH'(DEPTH));
      empty  <= (count_next == '0);
      afull  <= (count_next >= PTR_WIDTH'(ALMOST_FULL_NUM));
      aempty <= (count_next <= PTR_WIDTH'(ALMOST_EMPTY_NUM));
    end
  end

  fifo_sdp_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr[DEPTH_WIDTH-1:0]),
    .wdata (bus.wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[DEPTH_WIDTH-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.wr_full        = full;
  assign bus.rd_empty       = empty;
  assign bus.almost_full    = afull;
  assign bus.almost_empty   = aempty;
  assign bus.wr_water_level = level;
  assign bus.rd_water_level = level;

endmodule

// File: tb/tb_sync_fifo_16x2048.sv
// Scoreboard bench for the 2048x16 FIFO: written words queue up, reads pop and compare.
module tb_sync_fifo_16x2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_16x2048_if bus ();

  sync_fifo_16x2048 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] sb[$];
  logic [15:0] exp_rd = '0;
  bit          rd_fired, wr_fired;
  int          n_cmp = 0;
  int          n_fail = 0;

  // One clock of stimulus; the scoreboard follows the accept rules using pre-edge occupancy.
  task automatic step(input logic r, input logic we, input logic [15:0] wd, input logic re);
    bit wacc, racc;
    rst         = r;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    wacc = we && (sb.size() < 2048);
    racc = re && (sb.size() > 0);
    rd_fired = 1'b0;
    wr_fired = 1'b0;
    if (r) begin
      sb.delete();
      exp_rd = '0;
    end else begin
      if (racc) begin
        exp_rd   = sb.pop_front();
        rd_fired = 1'b1;
      end
      if (wacc) begin
        sb.push_back(wd);
        wr_fired = 1'b1;
      end
    end
    #1;
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty got %b want 1", bus.rd_empty); end
    n_cmp++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_aempty got %b want 1", bus.almost_empty); end
    n_cmp++; if (bus.wr_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full got %b want 0", bus.wr_full); end
    n_cmp++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_afull got %b want 0", bus.almost_full); end
    n_cmp++; if (bus.wr_water_level !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_wlevel got %0d want 0", bus.wr_water_level); end
    n_cmp++; if (bus.rd_water_level !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_rlevel got %0d want 0", bus.rd_water_level); end
    n_cmp++; if (bus.rd_data !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_rdata got %h want 0000", bus.rd_data); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 2049; i++) begin
      step(1'b0, 1'b1, 16'(32'hFFFF - i), 1'b0);
      n_cmp++; if (bus.wr_water_level !== 12'(sb.size())) begin n_fail++; $display("[TB] FAIL fill_level i=%0d got %0d want %0d", i, bus.wr_water_level, sb.size()); end
      n_cmp++; if (bus.almost_full !== (sb.size() >= 1020)) begin n_fail++; $display("[TB] FAIL fill_afull i=%0d got %b want %b", i, bus.almost_full, sb.size() >= 1020); end
      n_cmp++; if (bus.wr_full !== (sb.size() == 2048)) begin n_fail++; $display("[TB] FAIL fill_full i=%0d got %b want %b", i, bus.wr_full, sb.size() == 2048); end
    end
    n_cmp++; if (bus.rd_water_level !== 12'd2048) begin n_fail++; $display("[TB] FAIL fill_final_level got %0d want 2048", bus.rd_water_level); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 2049; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      n_cmp++; if (bus.rd_data !== exp_rd) begin n_fail++; $display("[TB] FAIL drain_data i=%0d got %h want %h", i, bus.rd_data, exp_rd); end
      n_cmp++; if (bus.rd_water_level !== 12'(sb.size())) begin n_fail++; $display("[TB] FAIL drain_level i=%0d got %0d want %0d", i, bus.rd_water_level, sb.size()); end
      n_cmp++; if (bus.almost_empty !== (sb.size() <= 4)) begin n_fail++; $display("[TB] FAIL drain_aempty i=%0d got %b want %b", i, bus.almost_empty, sb.size() <= 4); end
      n_cmp++; if (bus.rd_empty !== (sb.size() == 0)) begin n_fail++; $display("[TB] FAIL drain_empty i=%0d got %b want %b", i, bus.rd_empty, sb.size() == 0); end
    end
    n_cmp++; if (bus.rd_data !== 16'hF800) begin n_fail++; $display("[TB] FAIL drain_hold got %h want f800", bus.rd_data); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(16'h0A00 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 16'($urandom), 1'b1);
      n_cmp++; if (bus.wr_water_level !== 12'd5) begin n_fail++; $display("[TB] FAIL b2b_level i=%0d got %0d want 5", i, bus.wr_water_level); end
      n_cmp++; if (bus.rd_data !== exp_rd) begin n_fail++; $display("[TB] FAIL b2b_data i=%0d got %h want %h", i, bus.rd_data, exp_rd); end
    end
  endtask

  task automatic test_full_empty_both();
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 2048; i++) step(1'b0, 1'b1, 16'(i * 3), 1'b0);
    n_cmp++; if (bus.wr_full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_before got %b want 1", bus.wr_full); end
    step(1'b0, 1'b1, 16'hBEEF, 1'b1);
    n_cmp++; if (bus.wr_water_level !== 12'd2047) begin n_fail++; $display("[TB] FAIL full_both_level got %0d want 2047", bus.wr_water_level); end
    n_cmp++; if (bus.wr_full !== 1'b0) begin n_fail++; $display("[TB] FAIL full_both_flag got %b want 0", bus.wr_full); end
    n_cmp++; if (bus.rd_data !== exp_rd) begin n_fail++; $display("[TB] FAIL full_both_data got %h want %h", bus.rd_data, exp_rd); end
    for (int i = 0; i < 2047; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      n_cmp++; if (bus.rd_data !== exp_rd) begin n_fail++; $display("[TB] FAIL full_drain_data i=%0d got %h want %h", i, bus.rd_data, exp_rd); end
    end
    step(1'b0, 1'b1, 16'hABCD, 1'b1);
    n_cmp++; if (bus.rd_water_level !== 12'd1) begin n_fail++; $display("[TB] FAIL empty_both_level got %0d want 1", bus.rd_water_level); end
    n_cmp++; if (bus.rd_data !== exp_rd) begin n_fail++; $display("[TB] FAIL empty_both_hold got %h want %h", bus.rd_data, exp_rd); end
    n_cmp++; if (bus.rd_empty !== 1'b0) begin n_fail++; $display("[TB] FAIL empty_both_flag got %b want 0", bus.rd_empty); end
    step(1'b0, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (bus.rd_data !== 16'hABCD) begin n_fail++; $display("[TB] FAIL empty_both_word got %h want abcd", bus.rd_data); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 16'(16'h7000 + i), 1'b0);
    n_cmp++; if (bus.wr_water_level !== 12'd100) begin n_fail++; $display("[TB] FAIL mid_pre_level got %0d want 100", bus.wr_water_level); end
    step(1'b1, 1'b1, 16'h5555, 1'b1);
    n_cmp++; if (bus.wr_water_level !== 12'd0) begin n_fail++; $display("[TB] FAIL mid_level got %0d want 0", bus.wr_water_level); end
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_empty got %b want 1", bus.rd_empty); end
    n_cmp++; if (bus.rd_data !== 16'h0) begin n_fail++; $display("[TB] FAIL mid_rdata got %h want 0000", bus.rd_data); end
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (bus.rd_data !== 16'h1234) begin n_fail++; $display("[TB] FAIL mid_newword got %h want 1234", bus.rd_data); end
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_after_empty got %b want 1", bus.rd_empty); end
  endtask

  task automatic test_wrap();
    int  pushed = 0;
    int  cycles = 0;
    bit  we, re;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    while ((pushed < 5000 || sb.size() > 0) && cycles < 20000) begin
      we = (pushed < 5000) && (sb.size() < 14) && ($urandom_range(0, 3) != 0);
      re = (sb.size() > 6 || pushed >= 5000) && ($urandom_range(0, 3) != 0);
      step(1'b0, we, 16'($urandom), re);
      cycles++;
      if (wr_fired) pushed++;
      if (rd_fired) begin
        n_cmp++; if (bus.rd_data !== exp_rd) begin n_fail++; $display("[TB] FAIL wrap_data cyc=%0d got %h want %h", cycles, bus.rd_data, exp_rd); end
      end
      n_cmp++; if (bus.rd_water_level !== 12'(sb.size())) begin n_fail++; $display("[TB] FAIL wrap_level cyc=%0d got %0d want %0d", cycles, bus.rd_water_level, sb.size()); end
    end
    n_cmp++; if (cycles >= 20000) begin n_fail++; $display("[TB] FAIL wrap_budget got %0d cycles want < 20000", cycles); end
    n_cmp++; if (bus.rd_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_end_empty got %b want 1", bus.rd_empty); end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_empty_both();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
